// File: rtl/seven_segment_pkg.sv
// Shared seven-segment definitions.
// Holds the active-low segment patterns for the hex glyphs 0..F, the blank
// pattern and the bit position of each segment within the 7-bit bus
// (bit 6 = a ... bit 0 = g). The display encoder and the capture block
// both take their patterns from here so the two ends cannot drift apart.
package seven_segment_pkg;

  localparam int SEG_W     = 7;
  localparam int SEG_A_BIT = 6;
  localparam int SEG_B_BIT = 5;
  localparam int SEG_C_BIT = 4;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 2;
  localparam int SEG_F_BIT = 1;
  localparam int SEG_G_BIT = 0;

  // Active-low: a 0 bit lights the segment.
  localparam logic [SEG_W-1:0] SEG_0     = 7'h01;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h4C;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h20;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h0F;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h04;
  localparam logic [SEG_W-1:0] SEG_A     = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B     = 7'h60;
  localparam logic [SEG_W-1:0] SEG_C     = 7'h31;
  localparam logic [SEG_W-1:0] SEG_D     = 7'h42;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_F     = 7'h38;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seven_segment_decode.sv
// Combinational seven-segment pattern decoder.
// Ports:
//   seg    in  7  active-low segment pattern, bit 6 = a ... bit 0 = g
//   nibble out 4  hex value of the glyph (0 for blank or unknown)
//   blank  out 1  all segments off
//   err    out 1  pattern is neither a hex glyph nor blank
module seven_segment_decode
  import seven_segment_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic [3:0]       nibble,
  output logic             blank,
  output logic             err
);

  always_comb begin
    nibble = 4'h0;
    blank  = 1'b0;
    err    = 1'b0;
    case (seg)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: blank  = 1'b1;
      default:   err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_segment_capture.sv
// Seven-segment display bus capture.
// Observes the multiplexed anode/segment nets, accepts a digit once its
// pattern has been stable long enough, and publishes the whole displayed
// word once every digit has been seen at least once.
// Ports:
//   clk_i    in   1         system clock
//   rst_i    in   1         synchronous active-high reset
//   an_i     in   DIGITS    anode selects, active-low
//   seg_i    in   7         segments, active-low, bit 6 = a ... bit 0 = g
//   value_o  out  4*DIGITS  reassembled word, digit k at [4k+3:4k]
//   blank_o  out  DIGITS    digit k was blank in the last frame
//   err_o    out  DIGITS    digit k showed an unknown pattern in the last frame
//   valid_o  out  1         one-cycle pulse when the outputs update
module seven_segment_capture
  import seven_segment_pkg::*;
#(
  parameter  int DIGITS        = 8,
  parameter  int STABLE_CYCLES = 4,
  localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DIGITS-1:0]     an_i,
  input  logic [SEG_W-1:0]      seg_i,
  output logic [4*DIGITS-1:0]   value_o,
  output logic [DIGITS-1:0]     blank_o,
  output logic [DIGITS-1:0]     err_o,
  output logic                  valid_o
);

  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_COMMIT = CNT_W'(STABLE_CYCLES - 1);

  // True when exactly one anode line is driven low.
  function automatic logic one_hot_low(input logic [DIGITS-1:0] an);
    logic [DIGITS-1:0] sel;
    sel = ~an;
    return (sel != '0) && ((sel & (sel - 1'b1)) == '0);
  endfunction

  logic [DIGITS-1:0]   an_p0;
  logic [SEG_W-1:0]    seg_p0;
  logic [CNT_W-1:0]    cnt_p0;
  logic [DIGITS-1:0]   seen;
  logic [4*DIGITS-1:0] shadow_val;
  logic [DIGITS-1:0]   shadow_blank;
  logic [DIGITS-1:0]   shadow_err;

  logic                stable;
  logic                commit;
  logic [DIGITS-1:0]   commit_mask;
  logic [3:0]          dec_nibble;
  logic                dec_blank;
  logic                dec_err;

  // The counter describes the sample held in an_p0/seg_p0: it restarts on
  // the edge a new sample is loaded and climbs while each following pin
  // sample repeats it. Reaching STABLE_CYCLES therefore happens on the
  // edge N+STABLE_CYCLES for a pattern first sampled at edge N, and the
  // decode can use the registered segment value because it equals the pins.
  assign stable      = (an_i == an_p0) && (seg_i == seg_p0) && one_hot_low(an_i);
  assign commit      = stable && (cnt_p0 == CNT_COMMIT);
  assign commit_mask = commit ? ~an_p0 : '0;

  seven_segment_decode u_decode (
    .seg    (seg_p0),
    .nibble (dec_nibble),
    .blank  (dec_blank),
    .err    (dec_err)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      an_p0        <= '0;
      seg_p0       <= '0;
      cnt_p0       <= '0;
      seen         <= '0;
      shadow_val   <= '0;
      shadow_blank <= '0;
      shadow_err   <= '0;
      value_o      <= '0;
      blank_o      <= '0;
      err_o        <= '0;
      valid_o      <= 1'b0;
    end else begin
      // Stage p0: input register and stability counter
      an_p0  <= an_i;
      seg_p0 <= seg_i;
      if (!stable) begin
        cnt_p0 <= '0;
      end else if (cnt_p0 != CNT_MAX) begin
        cnt_p0 <= cnt_p0 + CNT_W'(1);
      end

      // Stage p1: commit into the shadow frame (last sample wins)
      for (int k = 0; k < DIGITS; k++) begin
        if (commit_mask[k]) begin
          shadow_val[4*k +: 4] <= dec_nibble;
          shadow_blank[k]      <= dec_blank;
          shadow_err[k]        <= dec_err;
        end
      end

      // Stage p2: publish a completed frame. A commit landing on the
      // publishing edge starts the next frame instead of being dropped.
      if (&seen) begin
        value_o <= shadow_val;
        blank_o <= shadow_blank;
        err_o   <= shadow_err;
        valid_o <= 1'b1;
        seen    <= commit_mask;
      end else begin
        valid_o <= 1'b0;
        seen    <= seen | commit_mask;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_capture.sv
module tb_seven_segment_capture;

  logic        clk_i;
  logic        rst_i;
  logic [7:0]  an_i;
  logic [6:0]  seg_i;
  logic [31:0] value_o;
  logic [7:0]  blank_o;
  logic [7:0]  err_o;
  logic        valid_o;

  seven_segment_capture #(.DIGITS(8), .STABLE_CYCLES(4)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .an_i    (an_i),
    .seg_i   (seg_i),
    .value_o (value_o),
    .blank_o (blank_o),
    .err_o   (err_o),
    .valid_o (valid_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Glyph patterns written out independently of the design package.
  logic [6:0] segs [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                            7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  typedef struct {
    logic [31:0] v;
    logic [7:0]  b;
    logic [7:0]  e;
    int          c;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  int          vld_count = 0;
  logic [31:0] exp_v;
  logic [7:0]  exp_b;
  logic [7:0]  exp_e;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT publishes a frame.
  always @(negedge clk_i) begin
    exp_t e;
    if (valid_o) begin
      vld_count++;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got value %h with no frame expected (cycle %0d)", value_o, cyc);
      end else begin
        e = q.pop_front();
        chk("frame_value", value_o, e.v);
        chk("frame_blank", {24'h0, blank_o}, {24'h0, e.b});
        chk("frame_err",   {24'h0, err_o},   {24'h0, e.e});
        chk("frame_cycle", cyc, e.c);
      end
    end else if (q.size() > 0 && cyc > q[0].c) begin
      tests++;
      fails++;
      $display("FAIL missing_valid: no pulse by cycle %0d, expected at %0d", cyc, q[0].c);
      void'(q.pop_front());
    end
  end

  function automatic logic [7:0] sel(input int k);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << k);
  endfunction

  // Present one anode/segment pair for n sampling edges. When fin is set
  // this is the digit that completes the frame: a 5+ sample dwell first
  // sampled at edge N commits at N+4 and publishes at N+5.
  task automatic show(input logic [7:0] a, input logic [6:0] s, input int n, input bit fin);
    an_i  = a;
    seg_i = s;
    if (fin) q.push_back('{exp_v, exp_b, exp_e, cyc + 6});
    repeat (n) @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    an_i  = 8'hFF;
    seg_i = 7'h7F;
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    int base;
    rst_i = 1'b1;
    an_i  = 8'hFF;
    seg_i = 7'h7F;
    repeat (3) @(negedge clk_i);
    chk("reset_value", value_o, 32'h0);
    chk("reset_blank", {24'h0, blank_o}, 32'h0);
    chk("reset_err",   {24'h0, err_o},   32'h0);
    chk("reset_valid", {31'h0, valid_o}, 32'h0);
    rst_i = 1'b0;
    idle(3);

    // 1: in-order scan showing 8,7,...,1 with a 6-cycle dwell
    exp_v = 32'h12345678; exp_b = 8'h00; exp_e = 8'h00;
    base = vld_count;
    for (int k = 0; k < 8; k++) show(sel(k), segs[8-k], 6, k == 7);
    idle(4);
    chk("t1_single_pulse", vld_count - base, 1);

    // 2a: 3-sample dwell never commits
    base = vld_count;
    for (int k = 0; k < 8; k++) show(sel(k), segs[k], 3, 1'b0);
    idle(8);
    chk("t2_short_dwell_no_valid", vld_count - base, 0);

    // 2b: pattern held through the commit edge; publish timing checked
    exp_v = 32'h76543210;
    for (int k = 0; k < 8; k++) show(sel(k), segs[k], 5, k == 7);
    idle(4);

    // 3: blank on digit 2, unknown 7'h55 on digit 5, 'A' elsewhere
    exp_v = 32'hAA0AA0AA; exp_b = 8'h04; exp_e = 8'h20;
    for (int k = 0; k < 8; k++)
      show(sel(k), (k == 2) ? 7'h7F : (k == 5) ? 7'h55 : segs[10], 6, k == 7);
    idle(4);

    // 4: digit 3 committed as '3', then glitched revisits and a two-low
    // anode must not disturb the frame
    exp_v = 32'hCCCC3CCC; exp_b = 8'h00; exp_e = 8'h00;
    for (int k = 0; k < 7; k++) show(sel(k), (k == 3) ? segs[3] : segs[12], 6, 1'b0);
    show(sel(3), segs[1], 3, 1'b0);
    show(sel(3), segs[14], 1, 1'b0);
    show(sel(3), segs[1], 3, 1'b0);
    show(8'hFC, segs[9], 6, 1'b0);
    show(sel(7), segs[12], 6, 1'b1);
    idle(4);

    // 5: out-of-order, digit 0 revisited with a new glyph
    exp_v = 32'h76543219;
    show(sel(7), segs[7], 6, 1'b0);
    show(sel(0), segs[5], 6, 1'b0);
    show(sel(0), segs[9], 6, 1'b0);
    show(sel(3), segs[3], 6, 1'b0);
    show(sel(1), segs[1], 6, 1'b0);
    show(sel(2), segs[2], 6, 1'b0);
    show(sel(4), segs[4], 6, 1'b0);
    show(sel(5), segs[5], 6, 1'b0);
    show(sel(6), segs[6], 6, 1'b1);
    idle(4);

    // 6: reset after five commits discards the partial frame
    for (int k = 0; k < 5; k++) show(sel(k), segs[15], 6, 1'b0);
    rst_i = 1'b1;
    idle(2);
    chk("t6_reset_value", value_o, 32'h0);
    chk("t6_reset_blank", {24'h0, blank_o}, 32'h0);
    chk("t6_reset_err",   {24'h0, err_o},   32'h0);
    chk("t6_reset_valid", {31'h0, valid_o}, 32'h0);
    rst_i = 1'b0;
    idle(2);
    exp_v = 32'h32187654;
    show(sel(5), segs[1], 6, 1'b0);
    show(sel(6), segs[2], 6, 1'b0);
    show(sel(7), segs[3], 6, 1'b0);
    for (int k = 0; k < 5; k++) show(sel(k), segs[4+k], 6, k == 4);
    idle(6);

    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
